// File: rtl/ascii_frame_sequencer.sv
// Turns a stream of ASCII decimal digits, one frame per terminator byte, into
// unsigned values delivered over valid/ready, with error reporting for bad input.
module ascii_frame_sequencer #(
    parameter int          MAX_DIGITS = 3,
    parameter int          OUT_W      = 8,
    parameter logic [7:0]  TERM       = 8'h0D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_byte,
    input  logic             rx_dv,
    output logic [OUT_W-1:0] val_out,
    output logic             val_valid,
    input  logic             val_ready,
    output logic             err,
    output logic [1:0]       err_code,
    output logic             busy
);
    localparam int ACC_W = OUT_W + 4;
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam logic [ACC_W-1:0] MAX_VAL = {4'b0000, {OUT_W{1'b1}}};

    localparam logic [1:0] E_OVERRUN = 2'b00;
    localparam logic [1:0] E_EMPTY   = 2'b01;
    localparam logic [1:0] E_BADCHR  = 2'b10;
    localparam logic [1:0] E_RANGE   = 2'b11;

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD, DISCARD} state_t;

    state_t             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovr_q;
    logic [OUT_W-1:0]   val_out_q;
    logic               val_valid_q;
    logic               err_q;
    logic [1:0]         err_code_q;
    logic               busy_q;

    logic               is_digit;
    logic               is_term;
    logic [3:0]         dig_val;
    logic [ACC_W-1:0]   acc_d;
    logic               range_bad;
    logic               ovr_d;

    // Low nibble of '0'..'9' is the digit value itself.
    assign is_digit  = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
    assign is_term   = (rx_byte == TERM);
    assign dig_val   = rx_byte[3:0];
    assign acc_d     = acc_q * ACC_W'(10) + {{(ACC_W-4){1'b0}}, dig_val};
    assign range_bad = (cnt_q == CNT_W'(MAX_DIGITS)) || (acc_d > MAX_VAL);
    // A byte dropped in HOLD on the handshake cycle still decides where we go next.
    assign ovr_d     = rx_dv ? !is_term : ovr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovr_q       <= 1'b0;
            val_out_q   <= '0;
            val_valid_q <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= E_OVERRUN;
            busy_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rx_dv) begin
                        if (is_digit) begin
                            acc_q   <= {{(ACC_W-4){1'b0}}, dig_val};
                            cnt_q   <= CNT_W'(1);
                            state_q <= ACCUM;
                            busy_q  <= 1'b1;
                        end else if (is_term) begin
                            err_q      <= 1'b1;
                            err_code_q <= E_EMPTY;
                        end else if (rx_byte != 8'h0A) begin
                            err_q      <= 1'b1;
                            err_code_q <= E_BADCHR;
                            state_q    <= DISCARD;
                            busy_q     <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (rx_dv) begin
                        if (is_digit) begin
                            if (range_bad) begin
                                err_q      <= 1'b1;
                                err_code_q <= E_RANGE;
                                state_q    <= DISCARD;
                            end else begin
                                acc_q <= acc_d;
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end else if (is_term) begin
                            val_out_q   <= acc_q[OUT_W-1:0];
                            val_valid_q <= 1'b1;
                            ovr_q       <= 1'b0;
                            state_q     <= HOLD;
                        end else begin
                            err_q      <= 1'b1;
                            err_code_q <= E_BADCHR;
                            state_q    <= DISCARD;
                        end
                    end
                end
                HOLD: begin
                    if (rx_dv) begin
                        err_q      <= 1'b1;
                        err_code_q <= E_OVERRUN;
                        ovr_q      <= ovr_d;
                    end
                    if (val_ready) begin
                        val_valid_q <= 1'b0;
                        if (ovr_d) begin
                            state_q <= DISCARD;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                DISCARD: begin
                    if (rx_dv && is_term) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign val_out   = val_out_q;
    assign val_valid = val_valid_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_ascii_frame_sequencer.sv
// Directed bench for ascii_frame_sequencer: drives bytes on the falling edge and
// checks registered outputs one falling edge later against hand-computed values.
module tb_ascii_frame_sequencer;
    logic       clk;
    logic       rst;
    logic [7:0] rx_byte;
    logic       rx_dv;
    logic [7:0] val_out;
    logic       val_valid;
    logic       val_ready;
    logic       err;
    logic [1:0] err_code;
    logic       busy;

    int n_tests;
    int n_fail;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    ascii_frame_sequencer #(
        .MAX_DIGITS (3),
        .OUT_W      (8),
        .TERM       (8'h0D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_byte   (rx_byte),
        .rx_dv     (rx_dv),
        .val_out   (val_out),
        .val_valid (val_valid),
        .val_ready (val_ready),
        .err       (err),
        .err_code  (err_code),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Presents one cycle of inputs; returns at the next falling edge, after the
    // rising edge that sampled them.
    task automatic tick(input logic dv, input logic [7:0] b, input logic rdy);
        rx_dv     = dv;
        rx_byte   = b;
        val_ready = rdy;
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic rdy);
        tick(1'b1, b, rdy);
    endtask

    task automatic idle(input logic rdy);
        tick(1'b0, 8'h00, rdy);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        rx_dv     = 1'b0;
        rx_byte   = 8'h00;
        val_ready = 1'b0;
        @(negedge clk);
        // A digit strobed during reset must be ignored.
        send("5", 1'b0);
        rst = 1'b0;
        chk("rst_busy",   busy,      0);
        chk("rst_valid",  val_valid, 0);
        chk("rst_val",    val_out,   0);
        chk("rst_err",    err,       0);
        chk("rst_code",   err_code,  0);
        idle(1'b0);
        chk("rst_dv_ign", busy,      0);

        // Valid frame "123" with consumer ready
        send("1", 1'b1);
        chk("t1_busy",  busy, 1);
        send("2", 1'b1);
        send("3", 1'b1);
        chk("t1_noerr", err, 0);
        send(CR, 1'b1);
        chk("t1_valid", val_valid, 1);
        chk("t1_val",   val_out,   123);
        chk("t1_err",   err,       0);
        idle(1'b1);
        chk("t1_vdrop", val_valid, 0);
        chk("t1_idle",  busy,      0);
        chk("t1_keep",  val_out,   123);

        // Upper bound 255 is legal
        send("2", 1'b1); send("5", 1'b1); send("5", 1'b1);
        chk("t255_err", err, 0);
        send(CR, 1'b1);
        chk("t255_val", val_out,   255);
        chk("t255_vld", val_valid, 1);
        idle(1'b1);

        // Range overflow 256, then recovery
        send("2", 1'b1); send("5", 1'b1); send("6", 1'b1);
        chk("t2_err",   err,       1);
        chk("t2_code",  err_code,  3);
        chk("t2_novld", val_valid, 0);
        idle(1'b1);
        chk("t2_pulse", err,  0);
        chk("t2_disc",  busy, 1);
        send(CR, 1'b1);
        chk("t2_cr_vld",  val_valid, 0);
        chk("t2_cr_idle", busy,      0);
        send("7", 1'b1); send(CR, 1'b1);
        chk("t2_val7", val_out,   7);
        chk("t2_vld7", val_valid, 1);
        idle(1'b1);

        // Too many digits
        send("1", 1'b1); send("2", 1'b1); send("3", 1'b1);
        chk("t2b_ok", err, 0);
        send("4", 1'b1);
        chk("t2b_err",  err,      1);
        chk("t2b_code", err_code, 3);
        send(CR, 1'b1);
        chk("t2b_idle", busy, 0);

        // Bad character, empty frame, LF, zero value
        send("4", 1'b1); send("A", 1'b1);
        chk("t3_err",  err,      1);
        chk("t3_code", err_code, 2);
        send("2", 1'b1);
        chk("t3_quiet", err, 0);
        send(CR, 1'b1);
        chk("t3_novld", val_valid, 0);
        chk("t3_idle",  busy,      0);
        send(CR, 1'b1);
        chk("t3_empty",  err,      1);
        chk("t3_ecode",  err_code, 1);
        chk("t3_ebusy",  busy,     0);
        send(LF, 1'b1);
        chk("t3_lf_err",  err,      0);
        chk("t3_lf_code", err_code, 1);
        chk("t3_lf_busy", busy,     0);
        send("0", 1'b1); send(CR, 1'b1);
        chk("t3_val0", val_out,   0);
        chk("t3_vld0", val_valid, 1);
        idle(1'b1);

        // Back-pressure with overrun
        send("9", 1'b0); send(CR, 1'b0);
        chk("t4_vld", val_valid, 1);
        chk("t4_val", val_out,   9);
        idle(1'b0);
        chk("t4_hold", val_valid, 1);
        send("8", 1'b0);
        chk("t4_ovr_err",  err,       1);
        chk("t4_ovr_code", err_code,  0);
        chk("t4_ovr_val",  val_out,   9);
        chk("t4_ovr_vld",  val_valid, 1);
        idle(1'b0);
        chk("t4_ovr_pulse", err, 0);
        idle(1'b0);
        idle(1'b1);
        chk("t4_hs_vld",  val_valid, 0);
        chk("t4_hs_disc", busy,      1);
        send("5", 1'b1);
        chk("t4_d5_err", err, 0);
        send(CR, 1'b1);
        chk("t4_dcr_vld",  val_valid, 0);
        chk("t4_dcr_idle", busy,      0);
        chk("t4_dcr_val",  val_out,   9);
        send("4", 1'b1); send(CR, 1'b1);
        chk("t4_val4", val_out,   4);
        chk("t4_vld4", val_valid, 1);
        idle(1'b1);

        // CR strobe on the handshake cycle
        send("6", 1'b0); send(CR, 1'b0);
        chk("t5_vld", val_valid, 1);
        send(CR, 1'b1);
        chk("t5_err",  err,       1);
        chk("t5_code", err_code,  0);
        chk("t5_vld0", val_valid, 0);
        chk("t5_idle", busy,      0);
        send("3", 1'b1); send(CR, 1'b1);
        chk("t5_val3", val_out,   3);
        chk("t5_vld3", val_valid, 1);
        idle(1'b1);

        // Reset mid-frame
        send("1", 1'b1); send("2", 1'b1);
        rst = 1'b1;
        idle(1'b1);
        rst = 1'b0;
        chk("t6_busy",  busy,      0);
        chk("t6_val",   val_out,   0);
        chk("t6_vld",   val_valid, 0);
        chk("t6_err",   err,       0);
        chk("t6_code",  err_code,  0);
        send("3", 1'b1); send(CR, 1'b1);
        chk("t6_val3", val_out,   3);
        chk("t6_vld3", val_valid, 1);
        idle(1'b1);

        // Reset during HOLD drops the pending result
        send("4", 1'b0); send(CR, 1'b0);
        rst = 1'b1;
        idle(1'b0);
        rst = 1'b0;
        chk("t7_vld",  val_valid, 0);
        chk("t7_busy", busy,      0);
        chk("t7_val",  val_out,   0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
